// File: rtl/regfile_pkg.sv
// Shared sizing, state encoding and helpers for the register file storage stage.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  function automatic int unsigned BE_W(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/reg_word.sv
// One storage word with byte-enable write and a synchronous clear that wins over write.
module reg_word
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [BE_W(WIDTH)-1:0]  be,
  input  logic [WIDTH-1:0]        d,
  input  logic                    clr,
  output logic [WIDTH-1:0]        q
);

  localparam int unsigned BW = BE_W(WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      for (int k = 0; k < BW; k++) begin
        if (be[k]) q[8*k +: 8] <= d[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/reg_bank32.sv
// 32-word register bank: write port with byte strobes, sequential clear engine, parallel word outputs.
module reg_bank32
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [BE_W(WIDTH)-1:0]  wr_be,
  input  logic                    clr_start,
  output logic                    busy,
  output logic                    clr_done,
  output logic [WIDTH-1:0]        Q0,  Q1,  Q2,  Q3,  Q4,  Q5,  Q6,  Q7,
  output logic [WIDTH-1:0]        Q8,  Q9,  Q10, Q11, Q12, Q13, Q14, Q15,
  output logic [WIDTH-1:0]        Q16, Q17, Q18, Q19, Q20, Q21, Q22, Q23,
  output logic [WIDTH-1:0]        Q24, Q25, Q26, Q27, Q28, Q29, Q30, Q31
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_d, busy_d, done_d;
  logic                wr_en;
  logic [WIDTH-1:0]    q_arr [NUM_REGS];

  // State, clear counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ready <= 1'b0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ready <= ready_d;
      busy     <= busy_d;
      clr_done <= done_d;
    end
  end

  // Next state; status outputs are derived from the next state so they line up with it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == CLEAR);
    done_d  = (state_d == CLEAR) && (cnt_d == LAST);
  end

  assign wr_en = wr_valid && wr_ready;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (ZERO_R0 && i == 0) begin : g_zero
      assign q_arr[i] = '0;
    end else begin : g_word
      logic we_i, clr_i;
      assign we_i  = wr_en && (wr_addr == ADDR_W'(i));
      assign clr_i = (state_q == CLEAR) && (cnt_q == ADDR_W'(i));
      reg_word #(.WIDTH(WIDTH)) u_word (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_i),
        .be    (wr_be),
        .d     (wr_data),
        .clr   (clr_i),
        .q     (q_arr[i])
      );
    end
  end

  assign Q0  = q_arr[0];  assign Q1  = q_arr[1];  assign Q2  = q_arr[2];  assign Q3  = q_arr[3];
  assign Q4  = q_arr[4];  assign Q5  = q_arr[5];  assign Q6  = q_arr[6];  assign Q7  = q_arr[7];
  assign Q8  = q_arr[8];  assign Q9  = q_arr[9];  assign Q10 = q_arr[10]; assign Q11 = q_arr[11];
  assign Q12 = q_arr[12]; assign Q13 = q_arr[13]; assign Q14 = q_arr[14]; assign Q15 = q_arr[15];
  assign Q16 = q_arr[16]; assign Q17 = q_arr[17]; assign Q18 = q_arr[18]; assign Q19 = q_arr[19];
  assign Q20 = q_arr[20]; assign Q21 = q_arr[21]; assign Q22 = q_arr[22]; assign Q23 = q_arr[23];
  assign Q24 = q_arr[24]; assign Q25 = q_arr[25]; assign Q26 = q_arr[26]; assign Q27 = q_arr[27];
  assign Q28 = q_arr[28]; assign Q29 = q_arr[29]; assign Q30 = q_arr[30]; assign Q31 = q_arr[31];

endmodule

// File: tb/tb_reg_bank32.sv
// Scoreboard bench for reg_bank32: a word-array model predicts every cycle, a monitor compares.
module tb_reg_bank32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        clr_start = 1'b0;

  logic        rdy1, bsy1, dn1, rdy0, bsy0, dn0;
  logic [31:0] q1 [32];
  logic [31:0] q0 [32];

  always #5 clk = ~clk;

  reg_bank32 #(.WIDTH(32), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy1), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .clr_start(clr_start), .busy(bsy1), .clr_done(dn1),
    .Q0(q1[0]), .Q1(q1[1]), .Q2(q1[2]), .Q3(q1[3]), .Q4(q1[4]), .Q5(q1[5]), .Q6(q1[6]), .Q7(q1[7]),
    .Q8(q1[8]), .Q9(q1[9]), .Q10(q1[10]), .Q11(q1[11]), .Q12(q1[12]), .Q13(q1[13]), .Q14(q1[14]),
    .Q15(q1[15]), .Q16(q1[16]), .Q17(q1[17]), .Q18(q1[18]), .Q19(q1[19]), .Q20(q1[20]),
    .Q21(q1[21]), .Q22(q1[22]), .Q23(q1[23]), .Q24(q1[24]), .Q25(q1[25]), .Q26(q1[26]),
    .Q27(q1[27]), .Q28(q1[28]), .Q29(q1[29]), .Q30(q1[30]), .Q31(q1[31])
  );

  reg_bank32 #(.WIDTH(32), .ZERO_R0(1'b0)) dut_r0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy0), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .clr_start(clr_start), .busy(bsy0), .clr_done(dn0),
    .Q0(q0[0]), .Q1(q0[1]), .Q2(q0[2]), .Q3(q0[3]), .Q4(q0[4]), .Q5(q0[5]), .Q6(q0[6]), .Q7(q0[7]),
    .Q8(q0[8]), .Q9(q0[9]), .Q10(q0[10]), .Q11(q0[11]), .Q12(q0[12]), .Q13(q0[13]), .Q14(q0[14]),
    .Q15(q0[15]), .Q16(q0[16]), .Q17(q0[17]), .Q18(q0[18]), .Q19(q0[19]), .Q20(q0[20]),
    .Q21(q0[21]), .Q22(q0[22]), .Q23(q0[23]), .Q24(q0[24]), .Q25(q0[25]), .Q26(q0[26]),
    .Q27(q0[27]), .Q28(q0[28]), .Q29(q0[29]), .Q30(q0[30]), .Q31(q0[31])
  );

  typedef struct packed {
    logic              rdy;
    logic              bsy;
    logic              dn;
    logic [31:0][31:0] m1;
    logic [31:0][31:0] m0;
  } exp_t;

  exp_t        expq [$];
  logic [31:0] m1 [32];
  logic [31:0] m0 [32];
  bit          m_rdy, m_busy, m_done;
  int          m_idx;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, act, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs now applied, then queue its prediction
  task automatic tick();
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m1[i] = '0; m0[i] = '0; end
      m_busy = 1'b0;
      m_idx  = 0;
    end else if (m_busy) begin
      m1[m_idx] = '0;
      m0[m_idx] = '0;
      m_idx++;
      if (m_idx == 32) begin m_busy = 1'b0; m_idx = 0; end
    end else begin
      if (wr_valid && m_rdy) begin
        if (wr_addr != 5'd0) m1[wr_addr] = merge(m1[wr_addr], wr_data, wr_be);
        m0[wr_addr] = merge(m0[wr_addr], wr_data, wr_be);
      end
      if (clr_start) begin m_busy = 1'b1; m_idx = 0; end
    end
    m_rdy  = rst_n && !m_busy;
    m_done = m_busy && (m_idx == 31);
    @(posedge clk);
    e.rdy = m_rdy;
    e.bsy = m_busy;
    e.dn  = m_done;
    for (int i = 0; i < 32; i++) begin e.m1[i] = m1[i]; e.m0[i] = m0[i]; end
    expq.push_back(e);
    @(negedge clk);
    #1;
  endtask

  // Hold a write request until the bank takes it; start_at pulses clr_start on that attempt
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b,
                          input int start_at);
    bit acc;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = b;
    for (int n = 0; n < 100; n++) begin
      clr_start = (n == start_at);
      acc = m_rdy && rst_n;
      tick();
      clr_start = 1'b0;
      if (acc) break;
      if (n == 99) begin
        checks++;
        errors++;
        $display("FAIL write_timeout addr=%0d: not accepted within 100 cycles", a);
      end
    end
    wr_valid = 1'b0;
  endtask

  // Monitor: every cycle the DUTs present registered state, compare it with the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("wr_ready", 1, 32'(rdy1), 32'(e.rdy));
      chk("busy", 1, 32'(bsy1), 32'(e.bsy));
      chk("clr_done", 1, 32'(dn1), 32'(e.dn));
      chk("wr_ready", 0, 32'(rdy0), 32'(e.rdy));
      chk("busy", 0, 32'(bsy0), 32'(e.bsy));
      chk("clr_done", 0, 32'(dn0), 32'(e.dn));
      for (int i = 0; i < 32; i++) begin
        chk("q_r0hard", i, q1[i], e.m1[i]);
        chk("q_r0free", i, q0[i], e.m0[i]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin m1[i] = '0; m0[i] = '0; end
    m_rdy = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_idx = 0;

    // Reset with an aggressive write request present
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    repeat (3) tick();
    rst_n = 1'b1;
    wr_valid = 1'b0;
    tick();

    // Full write/readback, then address 0 on both variants
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA5A5_0000 + 32'(i), 4'hF, -1);
    do_write(5'd0, 32'hDEAD_BEEF, 4'hF, -1);

    // Byte strobes, including an all-zero strobe
    do_write(5'd5, 32'h1122_3344, 4'hF, -1);
    do_write(5'd5, 32'hAABB_CCDD, 4'b0101, -1);
    do_write(5'd5, 32'h0000_0000, 4'b0000, -1);
    tick();

    // Clear started together with a write to 7, a stalled write, and an ignored clr_start
    do_write(5'd7, 32'h7777_0007, 4'hF, 0);
    do_write(5'd9, 32'h9999_0009, 4'b0011, 5);
    repeat (2) tick();

    // Reset in the middle of a clear, with a redundant clr_start before it
    for (int i = 1; i < 32; i++) do_write(5'(i), $urandom | 32'h1, 4'hF, -1);
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    repeat (3) tick();
    clr_start = 1'b1; tick(); clr_start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 39);
      if (r == 0) begin
        clr_start = 1'b1; tick(); clr_start = 1'b0;
      end else if (r < 28) begin
        do_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) == 0) ? 0 : -1);
      end else begin
        tick();
      end
    end
    repeat (3) tick();

    repeat (2) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d predictions left, expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
